data_memory_stack: RTL and testbench



---
 rtl/data_memory_stack.sv | 210 +++++++++++++++++++++
 tb/tb_data_memory_stack.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_stack.sv
// data_memory_stack
//
// Word-addressed data memory for the MEM stage with a hardware call/data
// stack living in the top STACK_DEPTH words of the same array. The stack
// grows downward from DEPTH. One operation is accepted per clock. LOAD/POP
// and RET results are registered and flagged with one-cycle valid pulses.
// Illegal accesses are blocked and latched into sticky error flags.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst_n      in   synchronous active-low reset (array contents are kept)
//   op         in   0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 NOP
//   address    in   byte address for LOAD/STORE (word index = address[31:2])
//   wdata      in   STORE/PUSH data
//   pc         in   current PC; CALL pushes pc+1
//   rdata      out  registered LOAD/POP result
//   rvalid     out  one-cycle pulse qualifying rdata
//   ret_pc     out  registered return address popped by RET
//   ret_valid  out  one-cycle pulse qualifying ret_pc
//   sp         out  index of top-of-stack entry, DEPTH when empty
//   count      out  number of entries on the stack
//   full       out  stack has STACK_DEPTH entries
//   empty      out  stack has no entries
//   err        out  sticky {addr_err, underflow, overflow}

module data_memory_stack #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int STACK_DEPTH = 64,
  parameter int SP_W        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        op,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] ret_pc,
  output logic              ret_valid,
  output logic [SP_W-1:0]   sp,
  output logic [SP_W-1:0]   count,
  output logic              full,
  output logic              empty,
  output logic [2:0]        err
);

  localparam int IDX_W      = $clog2(DEPTH);
  localparam int STACK_BASE = DEPTH - STACK_DEPTH;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] ret_pc_q, ret_pc_d;
  logic              ret_valid_q, ret_valid_d;
  logic [2:0]        err_q, err_d;

  logic              memWe;
  logic [IDX_W-1:0]  memWIdx;
  logic [DATA_W-1:0] memWData;
  logic [IDX_W-1:0]  memRIdx;
  logic [DATA_W-1:0] memRData;

  logic              addrLegal;
  logic              isFull;
  logic              isEmpty;
  op_e               opCur;

  assign opCur = op_e'(op);

  // A data access must be word aligned and must fall below the stack
  // region; the stack words are only reachable through stack operations.
  assign addrLegal = (address[1:0] == 2'b00) &&
                     (address[31:2] < 30'(STACK_BASE));

  assign isEmpty = (sp_q == SP_W'(DEPTH));
  assign isFull  = (sp_q == SP_W'(STACK_BASE));

  assign memRData = mem[memRIdx];

  // Operation decode. Every register gets a hold/idle default first, so
  // the valid pulses drop automatically on any cycle that does not
  // produce a result. The stack guards keep sp inside
  // [STACK_BASE, DEPTH], so the low IDX_W bits of sp are a valid array
  // index whenever the stack is non-empty.
  always_comb begin
    sp_d        = sp_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    ret_pc_d    = ret_pc_q;
    ret_valid_d = 1'b0;
    err_d       = err_q;
    memWe       = 1'b0;
    memWIdx     = '0;
    memWData    = '0;
    memRIdx     = '0;

    unique case (opCur)
      OP_LOAD: begin
        memRIdx  = address[IDX_W+1:2];
        rvalid_d = 1'b1;
        if (addrLegal) begin
          rdata_d = memRData;
        end else begin
          rdata_d  = '0;
          err_d[2] = 1'b1;
        end
      end
      OP_STORE: begin
        if (addrLegal) begin
          memWe    = 1'b1;
          memWIdx  = address[IDX_W+1:2];
          memWData = wdata;
        end else begin
          err_d[2] = 1'b1;
        end
      end
      OP_PUSH, OP_CALL: begin
        if (isFull) begin
          err_d[0] = 1'b1;
        end else begin
          sp_d     = sp_q - SP_W'(1);
          memWe    = 1'b1;
          memWIdx  = sp_d[IDX_W-1:0];
          memWData = (opCur == OP_CALL) ? (pc + DATA_W'(1)) : wdata;
        end
      end
      OP_POP, OP_RET: begin
        memRIdx = sp_q[IDX_W-1:0];
        if (opCur == OP_POP) begin
          rvalid_d = 1'b1;
        end else begin
          ret_valid_d = 1'b1;
        end
        if (isEmpty) begin
          err_d[1] = 1'b1;
          if (opCur == OP_POP) begin
            rdata_d = '0;
          end else begin
            ret_pc_d = '0;
          end
        end else begin
          sp_d = sp_q + SP_W'(1);
          if (opCur == OP_POP) begin
            rdata_d = memRData;
          end else begin
            ret_pc_d = memRData;
          end
        end
      end
      OP_NOP, OP_RSVD: begin
      end
      default: begin
      end
    endcase
  end

  // Control and result registers. Reset wins over any op at the same
  // edge, which also discards a result that would have been produced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q        <= SP_W'(DEPTH);
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      ret_pc_q    <= '0;
      ret_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      sp_q        <= sp_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      ret_pc_q    <= ret_pc_d;
      ret_valid_q <= ret_valid_d;
      err_q       <= err_d;
    end
  end

  // Single write port. The array is not cleared by reset, but an op that
  // coincides with reset must not write either.
  always_ff @(posedge clk) begin
    if (memWe && rst_n) begin
      mem[memWIdx] <= memWData;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign ret_pc    = ret_pc_q;
  assign ret_valid = ret_valid_q;
  assign sp        = sp_q;
  assign count     = SP_W'(DEPTH) - sp_q;
  assign full      = isFull;
  assign empty     = isEmpty;
  assign err       = err_q;

endmodule

// File: tb/tb_data_memory_stack.sv
// tb_data_memory_stack
//
// Directed testbench for data_memory_stack with default parameters.
// A small behavioural model of the array, stack pointer and error flags
// predicts each result; expected LOAD/POP and RET values are queued when
// the op is driven and popped when the DUT raises the matching valid.

module tb_data_memory_stack;

  localparam int DEPTH       = 256;
  localparam int STACK_DEPTH = 64;
  localparam int SP_W        = 9;
  localparam int STACK_BASE  = DEPTH - STACK_DEPTH;

  localparam logic [2:0] NOP   = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] STORE = 3'd2;
  localparam logic [2:0] PUSH  = 3'd3;
  localparam logic [2:0] POP   = 3'd4;
  localparam logic [2:0] CALL  = 3'd5;
  localparam logic [2:0] RET   = 3'd6;
  localparam logic [2:0] RSVD  = 3'd7;

  logic            clk;
  logic            rst_n;
  logic [2:0]      op;
  logic [31:0]     address;
  logic [31:0]     wdata;
  logic [31:0]     pc;
  logic [31:0]     rdata;
  logic            rvalid;
  logic [31:0]     ret_pc;
  logic            ret_valid;
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] count;
  logic            full;
  logic            empty;
  logic [2:0]      err;

  int testCount;
  int failCount;

  logic [31:0] mMem [DEPTH];
  int          mSp;
  logic [2:0]  mErr;
  logic [31:0] rdQ [$];
  logic [31:0] retQ [$];

  data_memory_stack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .address   (address),
    .wdata     (wdata),
    .pc        (pc),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .ret_pc    (ret_pc),
    .ret_valid (ret_valid),
    .sp        (sp),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err       (err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch count the failure and report.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model after an edge; a valid
  // pulse is expected exactly when a result is waiting in its queue.
  task automatic checkOutput(input string tag);
    logic [31:0] e;
    checkVal({tag, ".rvalid"}, 32'(rvalid), 32'(rdQ.size() != 0));
    if (rdQ.size() != 0) begin
      e = rdQ.pop_front();
      checkVal({tag, ".rdata"}, rdata, e);
    end
    checkVal({tag, ".ret_valid"}, 32'(ret_valid), 32'(retQ.size() != 0));
    if (retQ.size() != 0) begin
      e = retQ.pop_front();
      checkVal({tag, ".ret_pc"}, ret_pc, e);
    end
    checkVal({tag, ".sp"}, 32'(sp), 32'(mSp));
    checkVal({tag, ".count"}, 32'(count), 32'(DEPTH - mSp));
    checkVal({tag, ".full"}, 32'(full), 32'(mSp == STACK_BASE));
    checkVal({tag, ".empty"}, 32'(empty), 32'(mSp == DEPTH));
    checkVal({tag, ".err"}, 32'(err), 32'(mErr));
  endtask

  // Drive one op, predict its effect in the model, clock it in, check.
  task automatic applyStimulus(input string tag, input logic [2:0] o,
                               input logic [31:0] a, input logic [31:0] w,
                               input logic [31:0] p);
    logic legal;
    logic [31:0] d;
    op = o; address = a; wdata = w; pc = p;
    legal = (a[1:0] == 2'b00) && (a[31:2] < 30'(STACK_BASE));
    case (o)
      LOAD: begin
        if (legal) rdQ.push_back(mMem[a[9:2]]);
        else begin rdQ.push_back(32'h0); mErr[2] = 1'b1; end
      end
      STORE: begin
        if (legal) mMem[a[9:2]] = w;
        else mErr[2] = 1'b1;
      end
      PUSH, CALL: begin
        d = (o == CALL) ? p + 32'd1 : w;
        if (mSp == STACK_BASE) mErr[0] = 1'b1;
        else begin mSp--; mMem[mSp] = d; end
      end
      POP, RET: begin
        if (mSp == DEPTH) begin
          d = 32'h0; mErr[1] = 1'b1;
        end else begin
          d = mMem[mSp]; mSp++;
        end
        if (o == POP) rdQ.push_back(d);
        else retQ.push_back(d);
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Reset for one edge while an arbitrary op is presented.
  task automatic doReset(input string tag, input logic [2:0] o);
    rst_n = 1'b0;
    op = o; address = '0; wdata = '0; pc = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op = NOP;
    mSp = DEPTH;
    mErr = 3'b000;
    rdQ.delete();
    retQ.delete();
    checkOutput(tag);
    checkVal({tag, ".rdata_rst"}, rdata, 32'h0);
    checkVal({tag, ".ret_pc_rst"}, ret_pc, 32'h0);
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    mSp = DEPTH;
    mErr = 3'b000;
    rst_n = 1'b0;
    op = NOP; address = '0; wdata = '0; pc = '0;
    @(posedge clk);
    #1;
    doReset("reset", NOP);

    applyStimulus("store_2fc", STORE, 32'h2FC, 32'hCAFEF00D, 32'h0);
    applyStimulus("store_4", STORE, 32'h4, 32'h12345678, 32'h0);
    applyStimulus("load_4", LOAD, 32'h4, 32'h0, 32'h0);
    applyStimulus("nop_after_load", NOP, 32'h0, 32'h0, 32'h0);

    applyStimulus("push_a", PUSH, 32'h0, 32'hAABBCCDD, 32'h0);
    applyStimulus("push_b", PUSH, 32'h0, 32'h11223344, 32'h0);
    applyStimulus("pop_b", POP, 32'h0, 32'h0, 32'h0);
    applyStimulus("pop_a", POP, 32'h0, 32'h0, 32'h0);

    applyStimulus("call", CALL, 32'h0, 32'h0, 32'h100);
    applyStimulus("ret", RET, 32'h0, 32'h0, 32'h0);
    checkVal("ret.rdata_hold", rdata, 32'hAABBCCDD);
    applyStimulus("call_wrap", CALL, 32'h0, 32'h0, 32'hFFFFFFFF);
    applyStimulus("ret_wrap", RET, 32'h0, 32'h0, 32'h0);
    applyStimulus("rsvd", RSVD, 32'h4, 32'h55555555, 32'h0);

    for (int i = 0; i < STACK_DEPTH; i++) begin
      applyStimulus("fill", PUSH, 32'h0, 32'h5000_0000 + 32'(i), 32'h0);
    end
    applyStimulus("push_overflow", PUSH, 32'h0, 32'hDEADBEEF, 32'h0);
    applyStimulus("load_2fc", LOAD, 32'h2FC, 32'h0, 32'h0);

    for (int i = 0; i < STACK_DEPTH; i++) begin
      applyStimulus("drain", POP, 32'h0, 32'h0, 32'h0);
    end
    applyStimulus("pop_underflow", POP, 32'h0, 32'h0, 32'h0);
    applyStimulus("load_misaligned", LOAD, 32'h302, 32'h0, 32'h0);
    applyStimulus("load_stack_region", LOAD, 32'h300, 32'h0, 32'h0);
    applyStimulus("store_stack_region", STORE, 32'h300, 32'h77777777, 32'h0);

    applyStimulus("pre_rst_push1", PUSH, 32'h0, 32'h1, 32'h0);
    applyStimulus("pre_rst_push2", PUSH, 32'h0, 32'h2, 32'h0);
    applyStimulus("pre_rst_push3", PUSH, 32'h0, 32'h3, 32'h0);
    doReset("reset_over_pop", POP);
    applyStimulus("post_rst_nop", NOP, 32'h0, 32'h0, 32'h0);
    applyStimulus("post_rst_load_4", LOAD, 32'h4, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
